// File: rtl/layer_sequencer.sv
// layer_sequencer: runs the enabled CNN stages in index order, with a per-stage watchdog and a latency counter
module layer_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_STAGES-1:0]         stage_mask,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic [$clog2(NUM_STAGES)-1:0] err_stage,
    output logic [CNT_W-1:0]              cycle_count
);
    localparam int SW = $clog2(NUM_STAGES);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH, S_ERROR} state_t;

    state_t                r_state, w_next;
    logic [NUM_STAGES-1:0] r_mask, r_stage_start;
    logic [TW-1:0]         r_timer, w_wcount;
    logic [SW-1:0]         r_cur, r_err, w_first, w_following, w_cur_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy, r_done, r_error;
    logic                  w_has_next, w_cur_done, w_timeout, w_accept;

    assign w_wcount    = r_timer + TW'(1);
    assign w_cur_done  = stage_done[r_cur];
    assign w_timeout   = w_wcount == TW'(TIMEOUT);
    assign w_accept    = r_state == S_IDLE && start && !abort;
    assign w_cur_next  = (r_state == S_IDLE) ? w_first : w_following;
    assign stage_start = r_stage_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign cur_stage   = r_cur;
    assign err_stage   = r_err;
    assign cycle_count = r_cnt;

    // lowest enabled stage of the incoming mask, and next enabled stage above the current one
    always_comb begin
        w_first     = '0;
        w_following = '0;
        w_has_next  = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (stage_mask[i])
                w_first = SW'(i);
            if (r_mask[i] && SW'(i) > r_cur) begin
                w_following = SW'(i);
                w_has_next  = 1'b1;
            end
        end
    end

    // next-state logic; abort overrides everything, done beats the watchdog
    always_comb begin
        w_next = r_state;
        if (abort)
            w_next = S_IDLE;
        else
            case (r_state)
                S_IDLE:   w_next = start ? ((|stage_mask) ? S_LAUNCH : S_FINISH) : S_IDLE;
                S_LAUNCH: w_next = S_WAIT;
                S_WAIT:   w_next = w_cur_done ? (w_has_next ? S_LAUNCH : S_FINISH)
                                              : (w_timeout ? S_ERROR : S_WAIT);
                S_FINISH: w_next = S_IDLE;
                S_ERROR:  w_next = S_ERROR;
                default:  w_next = S_IDLE;
            endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // registered outputs derived from the upcoming state, plus mask, timer and latency bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_start <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_cur         <= '0;
            r_err         <= '0;
            r_cnt         <= '0;
            r_timer       <= '0;
            r_mask        <= '0;
        end else begin
            r_stage_start <= (w_next == S_LAUNCH) ? (NUM_STAGES'(1) << w_cur_next) : '0;
            r_busy        <= w_next == S_LAUNCH || w_next == S_WAIT;
            r_done        <= w_next == S_FINISH;
            r_error       <= w_next == S_ERROR;
            r_cur         <= (w_next == S_LAUNCH) ? w_cur_next : r_cur;
            r_err         <= (r_state == S_WAIT && w_next == S_ERROR) ? r_cur : r_err;
            r_timer       <= (r_state == S_WAIT) ? w_wcount : '0;
            r_mask        <= w_accept ? stage_mask : r_mask;
            if (!abort)
                r_cnt <= (r_state == S_IDLE && start) ? '0
                       : ((r_state == S_LAUNCH || r_state == S_WAIT || r_state == S_FINISH) && !(&r_cnt))
                         ? r_cnt + CNT_W'(1) : r_cnt;
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of stage ordering, watchdog, abort, reset and latency counting
module tb_layer_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [3:0]  stage_mask, mdone, man;
    logic [3:0]  stage_done;
    logic [3:0]  stage_start;
    logic        busy, done, error;
    logic [1:0]  cur_stage, err_stage;
    logic [31:0] cycle_count;

    int rem[4], lat[4], st_cnt[4], st_cyc[4], st_cur[4];
    int dn_cnt, dn_cyc, er_cyc, cyc, t0, n_chk, n_pass;
    bit er_seen;
    longint held;

    assign stage_done = mdone | man;

    layer_sequencer #(.NUM_STAGES(4), .TIMEOUT(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .stage_mask(stage_mask), .stage_done(stage_done), .stage_start(stage_start),
        .busy(busy), .done(done), .error(error), .cur_stage(cur_stage),
        .err_stage(err_stage), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // one cycle: log DUT outputs at the falling edge and run the stage response models
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (stage_start[i]) begin
                st_cnt[i]++;
                st_cyc[i] = cyc - t0;
                st_cur[i] = cur_stage;
            end
            mdone[i] = 1'b0;
            if (rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) mdone[i] = 1'b1;
            end
            if (stage_start[i] && lat[i] > 0) rem[i] = lat[i];
        end
        if (done) begin
            dn_cnt++;
            dn_cyc = cyc - t0;
        end
        if (error && !er_seen) begin
            er_seen = 1'b1;
            er_cyc  = cyc - t0;
        end
    endtask

    task automatic clear(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; st_cnt[i] = 0; st_cyc[i] = -1; st_cur[i] = -1;
        end
        mdone = '0; dn_cnt = 0; dn_cyc = -1; er_seen = 1'b0; er_cyc = -1;
    endtask

    task automatic go(input logic [3:0] m);
        tick();
        stage_mask = m;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to(input int k);
        for (int n = 0; n < 200 && cyc - t0 < k; n++) tick();
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && dn_cnt == 0; n++) tick();
    endtask

    task automatic wait_err(input int budget);
        for (int n = 0; n < budget && !er_seen; n++) tick();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; t0 = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; stage_mask = '0; man = '0;
        clear(5, 5, 5, 5);
        tick(); tick();
        check("rst_stage_start", stage_start, 0);
        check("rst_flags", {busy, done, error}, 0);
        check("rst_stages", {cur_stage, err_stage}, 0);
        check("rst_count", cycle_count, 0);
        reset = 1'b0;

        // all four stages, 5-cycle stage latency
        clear(5, 5, 5, 5);
        go(4'b1111);
        wait_done(100);
        check("full_st0", st_cyc[0], 1);
        check("full_st1", st_cyc[1], 7);
        check("full_st2", st_cyc[2], 13);
        check("full_st3", st_cyc[3], 19);
        check("full_done", dn_cyc, 25);
        tick();
        check("full_count", cycle_count, 25);
        check("full_busy", busy, 0);

        // sparse mask skips disabled stages
        clear(5, 5, 5, 5);
        go(4'b1010);
        wait_done(100);
        check("sparse_cnt", {st_cnt[0], st_cnt[1], st_cnt[2], st_cnt[3]}, {32'd0, 32'd1, 32'd0, 32'd1});
        check("sparse_cur1", st_cur[1], 1);
        check("sparse_cur3", st_cur[3], 3);
        check("sparse_done_lag", dn_cyc - st_cyc[3], 6);
        tick();
        check("sparse_count", cycle_count, 13);

        // stage 2 never answers
        clear(5, 5, 0, 5);
        go(4'b1111);
        wait_err(100);
        check("to_err_cycle", er_cyc, 46);
        check("to_err_stage", err_stage, 2);
        check("to_no_st3", st_cnt[3], 0);
        check("to_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("to_start_ignored", {error, busy}, 2'b10);
        check("to_no_relaunch", st_cnt[0], 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("to_abort_clear", {error, busy}, 0);
        check("to_err_stage_hold", err_stage, 2);

        // empty mask finishes straight away
        clear(5, 5, 5, 5);
        go(4'b0000);
        wait_done(10);
        check("m0_lat", (dn_cyc >= 1 && dn_cyc <= 2), 1);
        tick();
        check("m0_count", cycle_count, 1);
        check("m0_no_start", st_cnt[0] + st_cnt[1] + st_cnt[2] + st_cnt[3], 0);

        // done exactly on the last allowed WAIT cycle
        clear(32, 5, 5, 5);
        go(4'b0011);
        wait_done(100);
        check("b32_st1", st_cyc[1], 34);
        check("b32_no_err", er_seen, 0);
        check("b32_done", dn_cyc, 40);
        tick();
        check("b32_count", cycle_count, 40);

        // done one cycle too late
        clear(33, 5, 5, 5);
        go(4'b0001);
        wait_err(100);
        check("b33_err_cycle", er_cyc, 34);
        repeat (3) tick();
        check("b33_late_ignored", {error, dn_cnt[0]}, 2'b10);
        check("b33_err_stage", err_stage, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("b33_abort", error, 0);

        // spurious done for a non-active stage, then abort mid-WAIT
        clear(5, 5, 5, 5);
        go(4'b1111);
        run_to(9);
        man = 4'b1000;
        tick();
        man = '0;
        run_to(15);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("sp_st2", st_cyc[2], 13);
        check("ab_outputs", {busy, done, stage_start}, 0);
        check("ab_count", cycle_count, 14);
        held = cycle_count;
        repeat (10) tick();
        check("ab_count_frozen", cycle_count, held);
        check("ab_no_done", dn_cnt, 0);
        check("ab_no_st3", st_cnt[3], 0);

        // start and abort together
        clear(5, 5, 5, 5);
        tick();
        stage_mask = 4'b1111;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        check("sa_no_launch", st_cnt[0] + st_cnt[1] + st_cnt[2] + st_cnt[3], 0);
        check("sa_idle", {busy, done}, 0);

        // reset mid-inference, stale done afterwards
        clear(5, 5, 5, 5);
        go(4'b1111);
        run_to(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_outputs", {busy, stage_start, cur_stage}, 0);
        check("mr_count", cycle_count, 0);
        repeat (8) tick();
        check("mr_stale_done", {busy, dn_cnt[0], st_cnt[1][0]}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
